// File: rtl/ascon_inv_permutation.sv
// Iterative Ascon inverse permutation: undoes the last a rounds of p^a,
// ROUNDS_PER_CYCLE inverse rounds per clock, with a valid/ready job handshake.
module ascon_inv_permutation #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  rounds_i,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  input  logic        abort_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        err_o,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o
);

  localparam int unsigned WORD_W  = 64;
  localparam int unsigned NWORDS  = 5;
  localparam int unsigned RND_W   = 4;
  localparam logic [RND_W-1:0] RPC = RND_W'(ROUNDS_PER_CYCLE);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2) begin : g_rpc_check
    $error("ROUNDS_PER_CYCLE must be 1 or 2");
  end

  typedef logic [NWORDS-1:0][WORD_W-1:0] state_t;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} fsm_e;

  // Forward 5-bit S-box on one column, x0 in the MSB.
  function automatic logic [4:0] sbox_fwd(input logic [4:0] v);
    logic a0, a1, a2, a3, a4;
    logic t0, t1, t2, t3, t4;
    a0 = v[4]; a1 = v[3]; a2 = v[2]; a3 = v[1]; a4 = v[0];
    a0 ^= a4; a4 ^= a3; a2 ^= a1;
    t0 = ~a0 & a1; t1 = ~a1 & a2; t2 = ~a2 & a3; t3 = ~a3 & a4; t4 = ~a4 & a0;
    a0 ^= t1; a1 ^= t2; a2 ^= t3; a3 ^= t4; a4 ^= t0;
    a1 ^= a0; a0 ^= a4; a3 ^= a2; a2 = ~a2;
    return {a0, a1, a2, a3, a4};
  endfunction

  // Inverse S-box table built at elaboration by inverting the forward map.
  function automatic logic [159:0] inv_lut();
    logic [159:0] lut;
    lut = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      lut[5*32'(sbox_fwd(5'(i))) +: 5] = 5'(i);
    end
    return lut;
  endfunction

  localparam logic [159:0] INV_SBOX = inv_lut();

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] y,
                                             input int unsigned n);
    int unsigned m;
    m = n % WORD_W;
    return (y >> m) | (y << ((WORD_W - m) % WORD_W));
  endfunction

  // L = 1 + R^a + R^b satisfies L^64 = 1, so L^-1 = L^63 = prod L^(2^i), i=0..5.
  function automatic logic [WORD_W-1:0] lin_inv(input logic [WORD_W-1:0] y,
                                                input int unsigned a,
                                                input int unsigned b);
    logic [WORD_W-1:0] z;
    z = y;
    for (int unsigned i = 0; i < 6; i++) begin
      z = z ^ rotr(z, a << i) ^ rotr(z, b << i);
    end
    return z;
  endfunction

  function automatic state_t inv_round(input state_t s, input logic [RND_W-1:0] r);
    state_t     t;
    logic [4:0] v;
    logic [4:0] u;
    t[0] = lin_inv(s[0], 19, 28);
    t[1] = lin_inv(s[1], 61, 39);
    t[2] = lin_inv(s[2], 1, 6);
    t[3] = lin_inv(s[3], 10, 17);
    t[4] = lin_inv(s[4], 7, 41);
    for (int unsigned j = 0; j < WORD_W; j++) begin
      v = {t[0][j], t[1][j], t[2][j], t[3][j], t[4][j]};
      u = INV_SBOX[5*32'(v) +: 5];
      t[0][j] = u[4]; t[1][j] = u[3]; t[2][j] = u[2]; t[3][j] = u[1]; t[4][j] = u[0];
    end
    t[2][7:0] = t[2][7:0] ^ {4'hF - r, r};
    return t;
  endfunction

  fsm_e             state, state_d;
  state_t           data, data_d, run_next;
  logic [RND_W-1:0] rnd, rnd_d, rem, rem_d;
  logic             err, err_d;
  logic             in_ready_d, out_valid_d;
  logic             legal;

  // Datapath for one RUN cycle: rounds r, r-1, ...
  always_comb begin
    run_next = data;
    for (int unsigned k = 0; k < ROUNDS_PER_CYCLE; k++) begin
      run_next = inv_round(run_next, rnd - RND_W'(k));
    end
  end

  assign legal = (rounds_i == 4'd6 || rounds_i == 4'd8 || rounds_i == 4'd12) &&
                 ((rounds_i % RPC) == 4'd0);

  always_comb begin
    state_d = state;
    data_d  = data;
    rnd_d   = rnd;
    rem_d   = rem;
    err_d   = err;
    case (state)
      IDLE: begin
        if (in_valid_i && !abort_i) begin
          data_d = {x4_i, x3_i, x2_i, x1_i, x0_i};
          err_d  = !legal;
          if (legal) begin
            rnd_d   = 4'd11;
            rem_d   = rounds_i;
            state_d = RUN;
          end else begin
            state_d = HOLD;
          end
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end else begin
          data_d = run_next;
          rnd_d  = (rnd >= RPC) ? rnd - RPC : '0;
          rem_d  = rem - RPC;
          if (rem == RPC) state_d = HOLD;
        end
      end
      HOLD: begin
        if (abort_i || (out_valid_o && out_ready_i)) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    // Valid trails entry into HOLD by one cycle and drops on handshake or abort.
    out_valid_d = (state == HOLD) && (state_d == HOLD);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      data        <= '0;
      rnd         <= '0;
      rem         <= '0;
      err         <= 1'b0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
    end else begin
      state       <= state_d;
      data        <= data_d;
      rnd         <= rnd_d;
      rem         <= rem_d;
      err         <= err_d;
      in_ready_o  <= in_ready_d;
      out_valid_o <= out_valid_d;
    end
  end

  assign err_o = err;
  assign x0_o  = data[0];
  assign x1_o  = data[1];
  assign x2_o  = data[2];
  assign x3_o  = data[3];
  assign x4_o  = data[4];

endmodule
